mem_port_arbiter: RTL and testbench

//  Shares one single-ported, variable-latency unified memory between the fetch

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access.
// Data has priority; a streak counter bounds fetch starvation and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ready_i,
  output logic        grant_dm_o,
  output logic        err_o
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] I_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  // The watchdog holds 0 in the first busy cycle, so TIMEOUT-1 marks the last allowed cycle.
  localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);

  logic [1:0]          state_reg, state_next;
  logic                owner_d_reg;
  logic [STREAK_W-1:0] streak_reg;
  logic [WD_W-1:0]     wd_reg;
  logic                mem_we_reg;
  logic [31:0]         mem_addr_reg;
  logic [31:0]         mem_wdata_reg;
  logic [31:0]         if_rdata_reg;
  logic [31:0]         dm_rdata_reg;
  logic                err_reg;

  logic        busy;
  logic        streak_full;
  logic        grant_d;
  logic        grant_i;
  logic        timeout;
  logic        done;
  logic [31:0] resp_data;

  assign busy        = (state_reg == I_BUSY) || (state_reg == D_BUSY);
  assign streak_full = (streak_reg == STREAK_MAX);
  assign grant_d     = (state_reg == IDLE) && dm_req_i && !(if_req_i && streak_full);
  assign grant_i     = (state_reg == IDLE) && !grant_d && if_req_i;
  // A ready arriving in the watchdog's last cycle wins over the abort.
  assign timeout     = busy && !mem_ready_i && (wd_reg == WD_LAST);
  assign done        = busy && (mem_ready_i || timeout);
  assign resp_data   = mem_ready_i ? mem_rdata_i : 32'h0;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) begin
          state_next = D_BUSY;
        end else if (grant_i) begin
          state_next = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (done) begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      owner_d_reg   <= 1'b0;
      streak_reg    <= '0;
      wd_reg        <= '0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'h0;
      mem_wdata_reg <= 32'h0;
      if_rdata_reg  <= 32'h0;
      dm_rdata_reg  <= 32'h0;
      err_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (grant_d) begin
        owner_d_reg   <= 1'b1;
        mem_we_reg    <= dm_we_i;
        mem_addr_reg  <= dm_addr_i;
        mem_wdata_reg <= dm_wdata_i;
        if (!if_req_i) begin
          streak_reg <= '0;
        end else if (!streak_full) begin
          streak_reg <= streak_reg + 1'b1;
        end
      end else if (grant_i) begin
        owner_d_reg  <= 1'b0;
        mem_we_reg   <= 1'b0;
        mem_addr_reg <= if_addr_i;
        streak_reg   <= '0;
      end

      if (grant_d || grant_i) begin
        wd_reg <= '0;
      end else if (busy) begin
        wd_reg <= wd_reg + 1'b1;
      end

      // Stores never touch dm_rdata, even when aborted by the watchdog.
      if (done) begin
        if (!owner_d_reg) begin
          if_rdata_reg <= resp_data;
        end else if (!mem_we_reg) begin
          dm_rdata_reg <= resp_data;
        end
      end

      if (timeout) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign mem_req_o   = busy;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign dm_rdata_o  = dm_rdata_reg;
  assign if_ack_o    = (state_reg == RESP) && !owner_d_reg;
  assign dm_ack_o    = (state_reg == RESP) && owner_d_reg;
  assign grant_dm_o  = (state_reg == D_BUSY) || ((state_reg == RESP) && owner_d_reg);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: requester/memory models, grant and ack scoreboards,
// a vector table of single transactions plus sequences for arbitration, timeout and reset.
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_ack_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ready_i;
  logic        grant_dm_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.MAX_D_STREAK(4), .TIMEOUT(255)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .grant_dm_o(grant_dm_o), .err_o(err_o)
  );

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } job_t;
  typedef struct { logic d; logic we; logic [31:0] addr; logic [31:0] wdata; } gnt_t;
  typedef struct {
    logic d; logic we; logic [31:0] addr; logic [31:0] wdata;
    logic pre; logic [31:0] pre_data; int lat; logic [31:0] exp_rdata;
  } vec_t;

  job_t        if_jobs[$];
  job_t        dm_jobs[$];
  gnt_t        gnt_exp[$];
  logic [31:0] if_exp[$];
  logic [31:0] dm_exp[$];
  logic [31:0] model_mem [logic [31:0]];
  vec_t        vecs[7];

  int   n_checks = 0;
  int   n_err = 0;
  int   n_txn = 0;
  int   cyc = 0;
  int   mem_lat, busy_cnt, req_len, last_req_len;
  int   if_req_cyc, dm_req_cyc, if_ack_cyc, dm_ack_cyc;
  logic req_prev, ack_prev;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic push_grant(input logic d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    gnt_t g;
    g.d = d; g.we = we; g.addr = addr; g.wdata = wdata;
    gnt_exp.push_back(g);
  endtask

  task automatic push_if(input logic [31:0] addr, input logic [31:0] exp);
    job_t j;
    j.we = 1'b0; j.addr = addr; j.wdata = 32'h0;
    if_jobs.push_back(j);
    if_exp.push_back(exp);
  endtask

  task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp);
    job_t j;
    j.we = we; j.addr = addr; j.wdata = wdata;
    dm_jobs.push_back(j);
    dm_exp.push_back(exp);
  endtask

  task automatic set_vec(input int i, input logic d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic pre, input logic [31:0] pre_data,
                         input int lat, input logic [31:0] exp_rdata);
    vecs[i].d = d; vecs[i].we = we; vecs[i].addr = addr; vecs[i].wdata = wdata;
    vecs[i].pre = pre; vecs[i].pre_data = pre_data; vecs[i].lat = lat;
    vecs[i].exp_rdata = exp_rdata;
  endtask

  // One clock of bench activity at the falling edge: monitors, memory model, requesters.
  task automatic tick();
    gnt_t g;
    @(negedge clk_i);
    if (!rst_ni) begin
      if_req_i = 1'b0; dm_req_i = 1'b0; mem_ready_i = 1'b0;
      busy_cnt = 0; req_len = 0; req_prev = 1'b0; ack_prev = 1'b0;
      return;
    end
    if (mem_req_o && !req_prev) begin
      if (gnt_exp.size() == 0) begin
        fail("unexpected_grant");
      end else begin
        g = gnt_exp.pop_front();
        check("grant_side", 32'(grant_dm_o), 32'(g.d));
        check("grant_we", 32'(mem_we_o), 32'(g.we));
        check("grant_addr", mem_addr_o, g.addr);
        if (g.we) check("grant_wdata", mem_wdata_o, g.wdata);
      end
    end
    if (mem_req_o) begin
      req_len++;
    end else if (req_prev) begin
      last_req_len = req_len;
      req_len = 0;
    end
    req_prev = mem_req_o;
    if (if_ack_o || dm_ack_o) begin
      check("ack_exclusive", 32'(if_ack_o & dm_ack_o), 32'd0);
      check("ack_single_cycle", 32'(ack_prev), 32'd0);
    end
    ack_prev = if_ack_o | dm_ack_o;
    if (if_ack_o) begin
      n_txn++;
      $display("txn %0d: fetch ack cycle %0d if_rdata=0x%08h", n_txn, cyc, if_rdata_o);
      if (if_exp.size() == 0) fail("unexpected_if_ack");
      else check("if_rdata", if_rdata_o, if_exp.pop_front());
      if_ack_cyc = cyc;
      if (if_jobs.size() != 0) if_jobs.delete(0);
    end
    if (dm_ack_o) begin
      n_txn++;
      $display("txn %0d: data ack cycle %0d dm_rdata=0x%08h", n_txn, cyc, dm_rdata_o);
      if (dm_exp.size() == 0) fail("unexpected_dm_ack");
      else check("dm_rdata", dm_rdata_o, dm_exp.pop_front());
      dm_ack_cyc = cyc;
      if (dm_jobs.size() != 0) dm_jobs.delete(0);
    end
    // Memory: ready after mem_lat wait cycles; stray ready with junk data whenever idle.
    if (mem_req_o) begin
      if (mem_lat >= 0 && busy_cnt == mem_lat) begin
        mem_ready_i = 1'b1;
        if (mem_we_o) begin
          model_mem[mem_addr_o] = mem_wdata_o;
          mem_rdata_i = 32'h5A5A_5A5A;
        end else begin
          mem_rdata_i = model_mem.exists(mem_addr_o) ? model_mem[mem_addr_o] : 32'hBAD0_0000;
        end
      end else begin
        mem_ready_i = 1'b0;
        mem_rdata_i = 32'h5A5A_5A5A;
      end
      busy_cnt++;
    end else begin
      mem_ready_i = 1'b1;
      mem_rdata_i = 32'h5A5A_5A5A;
      busy_cnt = 0;
    end
    if (if_jobs.size() != 0) begin
      if (!if_req_i) if_req_cyc = cyc;
      if_req_i = 1'b1;
      if_addr_i = if_jobs[0].addr;
    end else begin
      if_req_i = 1'b0;
    end
    if (dm_jobs.size() != 0) begin
      if (!dm_req_i) dm_req_cyc = cyc;
      dm_req_i = 1'b1;
      dm_we_i = dm_jobs[0].we;
      dm_addr_i = dm_jobs[0].addr;
      dm_wdata_i = dm_jobs[0].wdata;
    end else begin
      dm_req_i = 1'b0;
    end
  endtask

  task automatic run_jobs(input string name, input int budget);
    int n = 0;
    while ((if_jobs.size() != 0 || dm_jobs.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (if_jobs.size() != 0 || dm_jobs.size() != 0) begin
      fail({name, "_no_ack"});
      if_jobs.delete(); dm_jobs.delete(); if_exp.delete(); dm_exp.delete(); gnt_exp.delete();
    end
    check({name, "_grants_done"}, 32'(gnt_exp.size()), 32'd0);
  endtask

  initial begin
    vec_t v;
    int   lat_meas;
    int   di;
    int   fi;
    logic found;

    rst_ni = 1'b0;
    if_req_i = 1'b0; if_addr_i = 32'h0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;
    mem_ready_i = 1'b0; mem_rdata_i = 32'h0;
    mem_lat = 0; busy_cnt = 0; req_len = 0; last_req_len = 0;
    if_req_cyc = 0; dm_req_cyc = 0; if_ack_cyc = 0; dm_ack_cyc = 0;
    req_prev = 1'b0; ack_prev = 1'b0;

    //      i  d     we    addr          wdata         pre   pre_data      lat  exp_rdata
    set_vec(0, 1'b0, 1'b0, 32'h0040_0000, 32'h0,        1'b1, 32'h2008_0005, 0,   32'h2008_0005);
    set_vec(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0,        1'b1, 32'hDEAD_BEEF, 3,   32'hDEAD_BEEF);
    set_vec(2, 1'b1, 1'b1, 32'h0000_0100, 32'h1111_2222, 1'b0, 32'h0,        1,   32'hDEAD_BEEF);
    set_vec(3, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        1'b0, 32'h0,         2,   32'h1111_2222);
    set_vec(4, 1'b0, 1'b0, 32'h0040_0004, 32'h0,        1'b1, 32'h0000_0013, 5,   32'h0000_0013);
    set_vec(5, 1'b0, 1'b0, 32'h0040_0008, 32'h0,        1'b1, 32'h8765_4321, 254, 32'h8765_4321);
    set_vec(6, 1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        1'b1, 32'h0,         0,   32'h0);

    tick();
    tick();
    check("reset_ctrl", 32'({mem_req_o, mem_we_o, if_ack_o, dm_ack_o, grant_dm_o, err_o}), 32'd0);
    check("reset_mem_addr", mem_addr_o, 32'h0);
    check("reset_mem_wdata", mem_wdata_o, 32'h0);
    check("reset_rdata", if_rdata_o | dm_rdata_o, 32'h0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      if (v.pre) model_mem[v.addr] = v.pre_data;
      mem_lat = v.lat;
      push_grant(v.d, v.d & v.we, v.addr, v.wdata);
      if (v.d) push_dm(v.we, v.addr, v.wdata, v.exp_rdata);
      else push_if(v.addr, v.exp_rdata);
      run_jobs("vec", 600);
      lat_meas = v.d ? (dm_ack_cyc - dm_req_cyc + 1) : (if_ack_cyc - if_req_cyc + 1);
      check("vec_latency", 32'(lat_meas), 32'(v.lat + 3));
      check("vec_err_clear", 32'(err_o), 32'd0);
      tick();
      tick();
      check("vec_rdata_hold", v.d ? dm_rdata_o : if_rdata_o, v.exp_rdata);
    end

    // Simultaneous store and fetch with streak 0: data first, then fetch.
    mem_lat = 0;
    model_mem[32'h0040_0010] = 32'h0000_0A0A;
    push_grant(1'b1, 1'b1, 32'h0000_0054, 32'h0000_0007);
    push_grant(1'b0, 1'b0, 32'h0040_0010, 32'h0);
    push_dm(1'b1, 32'h0000_0054, 32'h0000_0007, 32'h0);
    push_if(32'h0040_0010, 32'h0000_0A0A);
    run_jobs("both", 100);
    check("both_ack_order", 32'(dm_ack_cyc < if_ack_cyc), 32'd1);
    tick();

    // Both held continuously: four data grants, then one fetch, repeating.
    di = 0;
    fi = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        model_mem[32'h0040_0100 + 32'(4 * fi)] = 32'h0100_0000 + 32'(fi);
        push_grant(1'b0, 1'b0, 32'h0040_0100 + 32'(4 * fi), 32'h0);
        push_if(32'h0040_0100 + 32'(4 * fi), 32'h0100_0000 + 32'(fi));
        fi++;
      end else begin
        model_mem[32'h0000_0200 + 32'(4 * di)] = 32'h3000_0000 + 32'(di);
        push_grant(1'b1, 1'b0, 32'h0000_0200 + 32'(4 * di), 32'h0);
        push_dm(1'b0, 32'h0000_0200 + 32'(4 * di), 32'h0, 32'h3000_0000 + 32'(di));
        di++;
      end
    end
    run_jobs("streak", 200);
    tick();

    // Memory never ready: abort after 255 request cycles.
    mem_lat = -1;
    push_grant(1'b0, 1'b0, 32'h0040_0020, 32'h0);
    push_if(32'h0040_0020, 32'h0);
    run_jobs("timeout", 400);
    check("timeout_err", 32'(err_o), 32'd1);
    check("timeout_req_len", 32'(last_req_len), 32'd255);
    tick();
    mem_lat = 0;
    model_mem[32'h0000_0004] = 32'h4444_0004;
    push_grant(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    push_dm(1'b0, 32'h0000_0004, 32'h0, 32'h4444_0004);
    run_jobs("after_timeout", 50);
    check("err_sticky", 32'(err_o), 32'd1);
    tick();

    // Reset asserted mid D_BUSY.
    mem_lat = -1;
    push_grant(1'b1, 1'b0, 32'h8000_0000, 32'h0);
    push_dm(1'b0, 32'h8000_0000, 32'h0, 32'h0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      tick();
      found = grant_dm_o;
    end
    if (!found) fail("reset_seq_no_grant");
    tick();
    tick();
    tick();
    check("pre_reset_busy", 32'({mem_req_o, grant_dm_o}), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_ctrl", 32'({mem_req_o, grant_dm_o, if_ack_o, dm_ack_o, err_o}), 32'd0);
    check("async_reset_addr", mem_addr_o, 32'h0);
    check("async_reset_rdata", if_rdata_o | dm_rdata_o, 32'h0);
    dm_jobs.delete(); dm_exp.delete(); gnt_exp.delete();
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    mem_lat = 0;
    model_mem[32'h0040_0030] = 32'h1357_9BDF;
    push_grant(1'b0, 1'b0, 32'h0040_0030, 32'h0);
    push_if(32'h0040_0030, 32'h1357_9BDF);
    run_jobs("post_reset", 50);
    check("post_reset_latency", 32'(if_ack_cyc - if_req_cyc + 1), 32'd3);
    check("post_reset_err", 32'(err_o), 32'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
